// File: rtl/led_frame_sequencer.sv
// Walks current_led over one frame, captures GRB pixels from the screen manager and hands
// them to the serializer over valid/ready, then holds a latch gap before the next frame.
module led_frame_sequencer #(
    parameter int MAX_POS          = 109,
    parameter int FRAME_GAP_CYCLES = 4000,
    localparam int LED_W           = $clog2(MAX_POS),
    localparam int GAP_W           = $clog2(FRAME_GAP_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [LED_W-1:0] current_led,
    input  logic [7:0]       led_green_intensity,
    input  logic [7:0]       led_red_intensity,
    input  logic [7:0]       led_blue_intensity,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        GAP
    } state_t;

    localparam logic [LED_W-1:0] LAST_LED = LED_W'(MAX_POS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP_CYCLES - 1);

    state_t             state, state_n;
    logic [LED_W-1:0]   current_led_n;
    logic [23:0]        pixel_data_n;
    logic               pixel_valid_n;
    logic               frame_start_n;
    logic               frame_done_n;
    logic               busy_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            current_led <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_n;
            current_led <= current_led_n;
            pixel_data  <= pixel_data_n;
            pixel_valid <= pixel_valid_n;
            frame_start <= frame_start_n;
            frame_done  <= frame_done_n;
            busy        <= busy_n;
            gap_cnt     <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        current_led_n = current_led;
        pixel_data_n  = pixel_data;
        pixel_valid_n = pixel_valid;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        busy_n        = busy;
        gap_cnt_n     = gap_cnt;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n       = ADDR;
                    current_led_n = '0;
                    frame_start_n = 1'b1;
                    busy_n        = 1'b1;
                end
            end
            ADDR: begin
                // Intensities have had a full cycle to settle against current_led.
                pixel_data_n  = {led_green_intensity, led_red_intensity, led_blue_intensity};
                pixel_valid_n = 1'b1;
                state_n       = WAIT;
            end
            WAIT: begin
                if (pixel_valid && pixel_ready) begin
                    pixel_valid_n = 1'b0;
                    if (current_led == LAST_LED) begin
                        current_led_n = '0;
                        frame_done_n  = 1'b1;
                        gap_cnt_n     = '0;
                        state_n       = GAP;
                    end else begin
                        current_led_n = current_led + LED_W'(1);
                        state_n       = ADDR;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    if (enable) begin
                        state_n       = ADDR;
                        frame_start_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/led_frame_sequencer.md
# led_frame_sequencer

Frame scheduler for the addressable LED strip: walks `current_led` across `0..MAX_POS-1`, samples the colour intensities returned combinationally by the screen manager, and hands each pixel to the strip serializer over a valid/ready handshake. After the last LED it holds a latch gap, then starts the next frame while `enable` is high. It sits between the screen manager, which it drives with `current_led`, and the bit-level LED serializer, which consumes `pixel_data`.

## Interface

Parameters:
- `MAX_POS`, 109: LEDs per frame. Sets `current_led` width to `$clog2(MAX_POS)`.
- `FRAME_GAP_CYCLES`, 4000: latch/reset gap between frames, in clock cycles (≥1).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  run request; frames start only while high.
- `current_led`  out  `$clog2(MAX_POS)`  LED index presented to the screen manager.
- `led_green_intensity`  in  8  green value for `current_led`, combinational from the screen manager.
- `led_red_intensity`  in  8  red value for `current_led`.
- `led_blue_intensity`  in  8  blue value for `current_led`.
- `pixel_data`  out  24  `{green, red, blue}` (GRB, green in [23:16]).
- `pixel_valid`  out  1  `pixel_data` holds a pixel for the serializer.
- `pixel_ready`  in  1  serializer accepts the pixel this cycle.
- `frame_start`  out  1  one-cycle pulse on the first ADDR cycle of each frame.
- `frame_done`  out  1  one-cycle pulse on the first GAP cycle, after the last pixel transfers.
- `busy`  out  1  high in every state except IDLE.

## Operation

- All outputs are registered. Reset values: `current_led`=0, `pixel_data`=0, `pixel_valid`=0, `frame_start`=0, `frame_done`=0, `busy`=0, state=IDLE, gap counter=0.
- IDLE:
  - `enable`=1 → ADDR. `current_led` is 0, and `frame_start` and `busy` are high in the first ADDR cycle.
- ADDR, one cycle. `current_led` is stable and the intensities settle.
  - At the closing edge: `pixel_data`←`{g,r,b}`, `pixel_valid`←1, → WAIT.
- WAIT. `pixel_valid`=1 and `pixel_data` are held stable until a transfer.
  - A transfer happens on an edge where `pixel_valid`=1 and `pixel_ready`=1.
  - On transfer, `pixel_valid`←0.
  - If `current_led`=MAX_POS-1: `current_led`←0, `frame_done`←1 for one cycle, gap counter←0, → GAP.
  - Otherwise: `current_led`←`current_led`+1, → ADDR.
- GAP counts FRAME_GAP_CYCLES cycles (counter width `$clog2(FRAME_GAP_CYCLES+1)`).
  - On the final count, if `enable`=1 → ADDR with a `frame_start` pulse.
  - On the final count, if `enable`=0 → IDLE with `busy`←0.
- `enable` is sampled only in IDLE and at the end of GAP. Deasserting it mid-frame lets the frame and its gap complete. No partial frames are ever emitted.
- `current_led` never exceeds MAX_POS-1. It changes only on a transfer edge.
- Intensity inputs are sampled only at the closing edge of ADDR and ignored elsewhere.
- `pixel_ready` is ignored while `pixel_valid`=0.
- Reset asserted mid-frame forces all reset values immediately. The pixel in flight is dropped and no `frame_done` is issued.

## Timing

- `enable` rises in IDLE → the first ADDR cycle (`frame_start`=1) follows one edge later.
- A pixel's `pixel_valid` rises one cycle after its `current_led` value appears.
- Per pixel with `pixel_ready` held high: 2 cycles (ADDR + one WAIT cycle).
- Frame period with no backpressure: 2·MAX_POS + FRAME_GAP_CYCLES cycles, measured from `frame_start` to the next `frame_start`.
- Each cycle of `pixel_ready`=0 in WAIT adds exactly one cycle.
- `frame_done` asserts on the edge of the last transfer and is high for exactly one cycle. `frame_start` and `frame_done` never coincide.

## Test plan

- Reset check: assert `rst` asynchronously, outside any clock edge. All outputs go to the listed reset values at once. `enable`=0 after release → `busy` stays 0 indefinitely.
- Single frame (MAX_POS=4, FRAME_GAP_CYCLES=3, `pixel_ready`=1, intensities = `{led,led+1,led+2}`):
  - pixels 0x000102, 0x010203, 0x020304, 0x030405 transfer at 2-cycle spacing;
  - `frame_done` occurs 8 cycles after `frame_start`;
  - the next `frame_start` occurs 11 cycles after the first.
- Backpressure: hold `pixel_ready`=0 for 5 cycles on LED 2. `pixel_data` and `current_led` stay stable, `pixel_valid` stays 1, and the frame lengthens by exactly 5 cycles.
- `enable` drop: deassert `enable` during LED 1 of a 4-LED frame. All 4 pixels still transfer, `frame_done` pulses, the gap elapses, then `busy`=0 and no further `frame_start` occurs.
- Reset mid-frame: pulse `rst` while in WAIT on LED 2. Outputs return to reset values with no `frame_done`. After release, with `enable`=1, the next frame restarts at LED 0.
- Gap boundary: with FRAME_GAP_CYCLES=1, exactly 1 cycle separates `frame_done` from the next `frame_start`.
